pop_adc_seq: RTL and testbench
==============================

Name: pop_adc_seq

Overview:
Parametrised multi-channel SPI ADC sequencer that drives an ADC128S-style serial ADC directly. It uses SPI mode 0 and addresses the next conversion in the current frame. It scans the channels enabled in a mask, in single-shot or continuous mode, and presents each conversion result tagged with its channel on a valid/ready output port. It sits between the board ADC pins and the sample consumers, and includes a sample sequence counter and overrun accounting.

Parameters:
NUM_CH, 8, number of ADC channels; mask width
CH_BITS, 3, channel address width; NUM_CH <= 2**CH_BITS
DATA_W, 12, result width; taken from the last DATA_W MISO bits of a frame
FRAME_W, 16, SCLK cycles per frame; FRAME_W >= ADDR_OFS+CH_BITS and FRAME_W >= DATA_W
ADDR_OFS, 2, zero MOSI bits sent before the address MSB
CLK_DIV, 2, system cycles per SCLK half-period (>=1)
GAP_CYC, 2, minimum system cycles with ssel high between frames (>=1)

Ports:
clk_1Mhz  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a scan when idle, ignored when busy
continuous  in  1  1 = rescan until deasserted; sampled at start and at each scan end
ch_mask  in  NUM_CH  enabled channels; sampled at start and at each scan boundary
spi_ssel_o  out  1  ADC chip select, active low
spi_sck_o  out  1  SCLK, idles low
spi_mosi_o  out  1  address bits, MSB first
spi_miso_i  in  1  ADC data
sample_valid  out  1  output register holds an unconsumed sample
sample_ready  in  1  consumer accepts when valid&&ready
sample_data  out  DATA_W  conversion result
sample_ch  out  CH_BITS  channel of sample_data
sample_seq  out  8  count of samples loaded, wraps 255->0, value of the current sample
overrun_cnt  out  8  dropped samples, saturates at 255
busy  out  1  high from the cycle after an accepted start until return to IDLE

Behaviour:
- Reset (asynchronous): spi_ssel_o=1, spi_sck_o=0, spi_mosi_o=0, sample_valid=0, sample_data=0, sample_ch=0, sample_seq=0, overrun_cnt=0, busy=0, FSM=IDLE. Reset asserted mid-frame aborts the frame immediately; no partial sample is produced.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> (SETUP | IDLE).
- IDLE: on start with ch_mask==0, stay IDLE, busy stays 0. On start with a nonzero mask, go to SETUP.
- SETUP: ssel low for CLK_DIV cycles. MOSI presents frame bit FRAME_W-1.
- SHIFT: SCLK toggles every CLK_DIV cycles, producing FRAME_W rising edges.
  - MISO is sampled in the cycle SCLK goes high.
  - MOSI updates in the cycle SCLK goes low.
  - SHIFT ends after the FRAME_W-th falling edge.
- HOLD: ssel low, SCLK low for CLK_DIV cycles.
- GAP: ssel high for GAP_CYC cycles.
- Frame length = 2*CLK_DIV*(FRAME_W+1) + GAP_CYC cycles; 70 cycles at the defaults.
- MOSI frame: ADDR_OFS zeros, then the CH_BITS address MSB-first, then zeros.
- Pipeline: the result of frame k belongs to the address sent in frame k-1.
- Scan of N enabled channels (ascending index order) = N+1 frames:
  - Frame 0 (prime) sends the first enabled channel; its data is discarded.
  - Frame i sends enabled channel i (i=1..N-1) and yields the result for channel i-1.
  - Frame N sends the first enabled channel again (dummy) and yields the result of the last channel.
- Continuous: if continuous=1 at scan end, the next scan starts in SETUP after GAP without another prime frame, continuing the address chain, so every frame yields a sample. ch_mask is resampled at the scan boundary. If the new mask is 0 or continuous=0, the block performs the final flush frame and goes to IDLE.
- Sample load at the end of HOLD:
  - If !sample_valid, or valid&&ready in the same cycle: load data/ch, sample_valid=1, sample_seq+=1 (first sample after reset has seq 1).
  - If valid&&!ready: drop the new sample, keep the old one, overrun_cnt+=1 (saturating).
- sample_valid clears the cycle after valid&&ready when no new load occurs in that cycle.
- busy drops in the cycle the FSM enters IDLE. A start pulse while busy is ignored.

Test Plan:
1. Defaults, mask=8'b0000_0001, single-shot, MISO model returns 12'hA5C for ch0 -> 2 frames, MOSI address bits 000 in both; one sample, data=A5C, ch=0, seq=1; busy high for 140 cycles.
2. mask=8'b1000_0101, single-shot, model data = 12'h100+ch -> 4 frames with MOSI addresses 0,2,7,0; samples (ch0,100), (ch2,102), (ch7,107), seq 1..3, in order.
3. Continuous, mask=0x03, ready=1; deassert continuous after 5 samples -> samples alternate ch0/ch1 with no extra prime frame between scans; scan end finishes with a flush frame; IDLE; ssel high.
4. sample_ready=0, single-shot over 4 channels -> first sample held unchanged, overrun_cnt=3. Then force 300 overruns -> overrun_cnt saturates at 255.
5. Assert reset for 1 cycle mid-SHIFT -> ssel=1 and sck=0 immediately; all outputs at reset values; next start runs a clean prime frame.
6. start with mask=0 -> no ssel activity, busy=0. start pulse while busy -> ignored; frame count unchanged.

Source files
------------

// File: rtl/pop_adc_seq.sv
// Multi-channel sequencer for an ADC128S-style SPI ADC (mode 0, address-ahead pipeline).
// Scans the channels enabled in a mask and emits channel-tagged results on a valid/ready port.
module pop_adc_seq #(
    parameter int NUM_CH   = 8,
    parameter int CH_BITS  = 3,
    parameter int DATA_W   = 12,
    parameter int FRAME_W  = 16,
    parameter int ADDR_OFS = 2,
    parameter int CLK_DIV  = 2,
    parameter int GAP_CYC  = 2
) (
    input  logic                clk_1Mhz,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic [NUM_CH-1:0]   ch_mask,
    output logic                spi_ssel_o,
    output logic                spi_sck_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [DATA_W-1:0]   sample_data,
    output logic [CH_BITS-1:0]  sample_ch,
    output logic [7:0]          sample_seq,
    output logic [7:0]          overrun_cnt,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(FRAME_W - 1);

    // Lowest enabled channel strictly above cur (or lowest overall when from_first);
    // the MSB of the result flags that a channel was found.
    function automatic logic [CH_BITS:0] pick_ch(input logic [NUM_CH-1:0]  m,
                                                 input logic [CH_BITS-1:0] cur,
                                                 input logic               from_first);
        logic [CH_BITS:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (from_first || (i > int'(cur)))) begin
                r = {1'b1, CH_BITS'(i)};
            end
        end
        return r;
    endfunction

    function automatic logic [FRAME_W-1:0] frame_word(input logic [CH_BITS-1:0] ch);
        logic [FRAME_W-1:0] w;
        w = '0;
        w[FRAME_W-1-ADDR_OFS -: CH_BITS] = ch;
        return w;
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     div_q, div_d;
    logic [EDGE_W-1:0]    edge_q, edge_d;
    logic                 sck_q, sck_d;
    logic                 ssel_q, ssel_d;
    logic [FRAME_W-1:0]   mosi_sr_q, mosi_sr_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [CH_BITS-1:0]   cur_ch_q, cur_ch_d;
    logic [CH_BITS-1:0]   res_ch_q, res_ch_d;
    logic                 have_res_q, have_res_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [CH_BITS-1:0]   ch_q, ch_d;
    logic [7:0]           seq_q, seq_d;
    logic [7:0]           ovr_q, ovr_d;

    logic [CH_BITS:0]     next_in_scan;
    logic [CH_BITS:0]     first_new;
    logic [CH_BITS:0]     first_old;

    assign next_in_scan = pick_ch(mask_q, cur_ch_q, 1'b0);
    assign first_new    = pick_ch(ch_mask, '0, 1'b1);
    assign first_old    = pick_ch(mask_q, '0, 1'b1);

    always_ff @(posedge clk_1Mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            mosi_sr_q  <= '0;
            shreg_q    <= '0;
            mask_q     <= '0;
            cur_ch_q   <= '0;
            res_ch_q   <= '0;
            have_res_q <= 1'b0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
            seq_q      <= '0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            mosi_sr_q  <= mosi_sr_d;
            shreg_q    <= shreg_d;
            mask_q     <= mask_d;
            cur_ch_q   <= cur_ch_d;
            res_ch_q   <= res_ch_d;
            have_res_q <= have_res_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ch_q       <= ch_d;
            seq_q      <= seq_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        sck_d      = sck_q;
        mosi_sr_d  = mosi_sr_q;
        shreg_d    = shreg_q;
        mask_d     = mask_q;
        cur_ch_d   = cur_ch_q;
        res_ch_d   = res_ch_q;
        have_res_d = have_res_q;
        last_d     = last_q;
        valid_d    = valid_q;
        data_d     = data_q;
        ch_d       = ch_q;
        seq_d      = seq_q;
        ovr_d      = ovr_q;

        // Output port: a sample transfers in any cycle with sample_valid && sample_ready;
        // sample_valid then drops unless a new sample is loaded in that same cycle.
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                edge_d = '0;
                sck_d  = 1'b0;
                if (start && (|ch_mask)) begin
                    state_d    = ST_SETUP;
                    mask_d     = ch_mask;
                    cur_ch_d   = first_new[CH_BITS-1:0];
                    have_res_d = 1'b0;
                    last_d     = 1'b0;
                    mosi_sr_d  = frame_word(first_new[CH_BITS-1:0]);
                end
            end

            ST_SETUP: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    edge_d  = '0;
                    state_d = ST_SHIFT;
                end
            end

            // Rising SCLK samples MISO; falling SCLK advances MOSI.
            ST_SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    if (!sck_q) begin
                        shreg_d = {shreg_q[DATA_W-2:0], spi_miso_i};
                    end else begin
                        mosi_sr_d = {mosi_sr_q[FRAME_W-2:0], 1'b0};
                        edge_d    = edge_q + 1'b1;
                        if (edge_q == EDGE_LAST) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
            end

            ST_HOLD: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_GAP;
                    if (have_res_q) begin
                        if (!valid_q || sample_ready) begin
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                            ch_d    = res_ch_q;
                            seq_d   = seq_q + 8'd1;
                        end else if (ovr_q != 8'hFF) begin
                            ovr_d = ovr_q + 8'd1;
                        end
                    end
                end
            end

            // The frame just finished carried the address whose result arrives next frame.
            ST_GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == GAP_LAST) begin
                    div_d = '0;
                    if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_SETUP;
                        res_ch_d   = cur_ch_q;
                        have_res_d = 1'b1;
                        if (next_in_scan[CH_BITS]) begin
                            cur_ch_d = next_in_scan[CH_BITS-1:0];
                        end else if (continuous && (|ch_mask)) begin
                            mask_d   = ch_mask;
                            cur_ch_d = first_new[CH_BITS-1:0];
                        end else begin
                            cur_ch_d = first_old[CH_BITS-1:0];
                            last_d   = 1'b1;
                        end
                        mosi_sr_d = frame_word(cur_ch_d);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                sck_d   = 1'b0;
            end
        endcase

        ssel_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
    end

    assign spi_ssel_o   = ssel_q;
    assign spi_sck_o    = sck_q;
    assign spi_mosi_o   = mosi_sr_q[FRAME_W-1];
    assign sample_valid = valid_q;
    assign sample_data  = data_q;
    assign sample_ch    = ch_q;
    assign sample_seq   = seq_q;
    assign overrun_cnt  = ovr_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pop_adc_seq.sv
// Directed bench for pop_adc_seq with a behavioural ADC128S model on the SPI pins
// and a scoreboard of expected samples and expected MOSI frame words.
module tb_pop_adc_seq;

    logic        clk_1Mhz = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic        spi_ssel_o, spi_sck_o, spi_mosi_o;
    logic        spi_miso_i = 1'b0;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic [7:0]  sample_seq;
    logic [7:0]  overrun_cnt;
    logic        busy;

    pop_adc_seq dut (
        .clk_1Mhz     (clk_1Mhz),
        .reset        (reset),
        .start        (start),
        .continuous   (continuous),
        .ch_mask      (ch_mask),
        .spi_ssel_o   (spi_ssel_o),
        .spi_sck_o    (spi_sck_o),
        .spi_mosi_o   (spi_mosi_o),
        .spi_miso_i   (spi_miso_i),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_seq   (sample_seq),
        .overrun_cnt  (overrun_cnt),
        .busy         (busy)
    );

    always #5 clk_1Mhz = ~clk_1Mhz;

    int chk_n = 0;
    int err_n = 0;
    logic [22:0] exp_q[$];       // {seq, ch, data}
    logic [15:0] exp_word_q[$];  // expected MOSI frame words
    logic [7:0]  seq_model = '0;
    int          data_mode = 0;
    logic [2:0]  prev_addr = '0;
    logic [15:0] miso_word = '0;
    logic [15:0] rx_word = '0;
    int          bit_i = 0;
    int          frame_cnt = 0;
    bit          chk_frames = 1'b0;
    int          rx_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_data(input logic [2:0] a);
        return (data_mode == 0) ? 12'hA5C : (12'h100 + {9'd0, a});
    endfunction

    // ADC model: result of the address received in the previous frame, MSB first,
    // first bit valid after CS falls, next bit after each SCLK falling edge.
    always @(negedge spi_ssel_o) begin
        miso_word  = {4'h0, model_data(prev_addr)};
        bit_i      = 15;
        spi_miso_i = miso_word[15];
        rx_word    = '0;
    end

    always @(negedge spi_sck_o) begin
        if (bit_i > 0) begin
            bit_i--;
            spi_miso_i = miso_word[bit_i];
        end
    end

    always @(posedge spi_sck_o) rx_word = {rx_word[14:0], spi_mosi_o};

    always @(posedge spi_ssel_o) begin
        prev_addr = rx_word[13:11];
        if (chk_frames) begin
            frame_cnt++;
            if (exp_word_q.size() == 0) check("frame_q_size", exp_word_q.size(), 1);
            else check("mosi_word", rx_word, exp_word_q.pop_front());
        end
    end

    always @(negedge clk_1Mhz) begin
        if (!reset && sample_valid === 1'b1 && sample_ready) begin
            logic [22:0] e;
            rx_cnt++;
            if (exp_q.size() == 0) begin
                check("sample_q_size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sample_data", sample_data, e[11:0]);
                check("sample_ch", sample_ch, e[14:12]);
                check("sample_seq", sample_seq, e[22:15]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1Mhz);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic c);
        ch_mask    = m;
        continuous = c;
        @(posedge clk_1Mhz); #1 start = 1'b1;
        @(posedge clk_1Mhz); #1 start = 1'b0;
    endtask

    task automatic push_sample(input logic [2:0] ch, input logic [11:0] d);
        seq_model++;
        exp_q.push_back({seq_model, ch, d});
    endtask

    task automatic push_frame(input logic [2:0] a);
        exp_word_q.push_back({2'b00, a, 11'd0});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk_1Mhz); #1;
            n++;
        end
        check(tag, busy, 1'b0);
        tick(3);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_samples_left"}, exp_q.size(), 0);
        check({tag, "_frames_left"}, exp_word_q.size(), 0);
    endtask

    initial begin
        int n;
        int lo;
        // reset values
        tick(3);
        check("rst_ssel", spi_ssel_o, 1'b1);
        check("rst_sck", spi_sck_o, 1'b0);
        check("rst_mosi", spi_mosi_o, 1'b0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_seq", sample_seq, 8'd0);
        check("rst_ovr", overrun_cnt, 8'd0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(2);

        // 1: single channel, two frames, 140 busy cycles
        chk_frames = 1'b1; frame_cnt = 0; data_mode = 0; sample_ready = 1'b1;
        push_frame(3'd0); push_frame(3'd0);
        push_sample(3'd0, 12'hA5C);
        pulse_start(8'b0000_0001, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(posedge clk_1Mhz); #1;
        end
        check("t1_busy_cycles", n, 140);
        tick(3);
        check("t1_frames", frame_cnt, 2);
        check_drained("t1");

        // 2: sparse mask, addresses 0,2,7,0
        frame_cnt = 0; data_mode = 1;
        push_frame(3'd0); push_frame(3'd2); push_frame(3'd7); push_frame(3'd0);
        push_sample(3'd0, 12'h100); push_sample(3'd2, 12'h102); push_sample(3'd7, 12'h107);
        pulse_start(8'b1000_0101, 1'b0);
        wait_idle("t2_idle", 1000);
        check("t2_frames", frame_cnt, 4);
        check_drained("t2");

        // 3: continuous over ch0/ch1, stop after five samples
        frame_cnt = 0; rx_cnt = 0;
        for (int i = 0; i < 7; i++) push_frame(3'(i % 2));
        for (int i = 0; i < 6; i++) push_sample(3'(i % 2), 12'h100 + 12'(i % 2));
        pulse_start(8'h03, 1'b1);
        n = 0;
        while (rx_cnt < 5 && n < 2000) begin
            @(negedge clk_1Mhz); #1;
            n++;
        end
        check("t3_five_samples", rx_cnt >= 5, 1'b1);
        continuous = 1'b0;
        wait_idle("t3_idle", 1000);
        check("t3_frames", frame_cnt, 7);
        check("t3_ssel", spi_ssel_o, 1'b1);
        check_drained("t3");

        // 4: consumer stalled, overruns then saturation
        sample_ready = 1'b0; frame_cnt = 0;
        for (int i = 0; i < 4; i++) push_frame(3'(i));
        push_frame(3'd0);
        push_sample(3'd0, 12'h100);
        pulse_start(8'h0F, 1'b0);
        wait_idle("t4_idle", 1000);
        check("t4_ovr3", overrun_cnt, 8'd3);
        check("t4_held_valid", sample_valid, 1'b1);
        check("t4_held_data", sample_data, 12'h100);
        check("t4_held_ch", sample_ch, 3'd0);
        check("t4_held_seq", sample_seq, seq_model);
        chk_frames = 1'b0;
        pulse_start(8'h01, 1'b1);
        tick(300 * 70);
        continuous = 1'b0;
        wait_idle("t4_sat_idle", 1000);
        check("t4_ovr_sat", overrun_cnt, 8'd255);
        check("t4_sat_data", sample_data, 12'h100);
        sample_ready = 1'b1;
        tick(3);
        check("t4_valid_clear", sample_valid, 1'b0);
        check_drained("t4");

        // 5: reset in the middle of SHIFT
        pulse_start(8'h01, 1'b0);
        tick(10);
        check("t5_in_frame", spi_ssel_o, 1'b0);
        reset = 1'b1;
        #1;
        check("t5_ssel", spi_ssel_o, 1'b1);
        check("t5_sck", spi_sck_o, 1'b0);
        check("t5_mosi", spi_mosi_o, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_valid", sample_valid, 1'b0);
        check("t5_data", sample_data, 12'h000);
        check("t5_ch", sample_ch, 3'd0);
        check("t5_seq", sample_seq, 8'd0);
        check("t5_ovr", overrun_cnt, 8'd0);
        tick(1);
        reset = 1'b0;
        tick(2);
        seq_model = '0; frame_cnt = 0; chk_frames = 1'b1;
        push_frame(3'd2); push_frame(3'd2);
        push_sample(3'd2, 12'h102);
        pulse_start(8'h04, 1'b0);
        wait_idle("t5_idle", 1000);
        check("t5_frames", frame_cnt, 2);
        check_drained("t5");

        // 6: empty mask, then start while busy
        frame_cnt = 0; n = 0; lo = 0;
        pulse_start(8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_1Mhz); #1;
            if (busy !== 1'b0) n++;
            if (spi_ssel_o !== 1'b1) lo++;
        end
        check("t6_busy_mask0", n, 0);
        check("t6_ssel_mask0", lo, 0);
        check("t6_frames_mask0", frame_cnt, 0);
        push_frame(3'd0); push_frame(3'd0);
        push_sample(3'd0, 12'h100);
        pulse_start(8'h01, 1'b0);
        tick(20);
        pulse_start(8'h02, 1'b0);
        wait_idle("t6_idle", 1000);
        check("t6_frames", frame_cnt, 2);
        check_drained("t6");

        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end

endmodule
